// File: rtl/a2d_spi_resp.sv
// SPI responder model of the 8-channel 12-bit IR-sensor A2D converter.
// Optional protocol checking: define A2D_SPI_RESP_PROTO_CHK_EN.
module a2d_spi_resp #(
    parameter logic [2:0] RST_CH = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [95:0] ch_vals,
    output logic [2:0]  cur_ch,
    output logic        frm_done,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_n;

    logic ss_s1, ss_s2, ss_d;
    logic sck_s1, sck_s2, sck_d;
    logic mosi_s1, mosi_s2;
    logic [1:0] flush;
    logic [15:0] tx, rx, rx_n;
    logic [4:0] bit_cnt, cnt_n;
    logic [7:0][11:0] ch_arr;

    logic ss_rise, ss_fall, sck_rise, sck_fall;
    logic end_frm;

    assign ch_arr   = ch_vals;
    assign ss_rise  = ss_s2 & ~ss_d;
    assign ss_fall  = ~ss_s2 & ss_d;
    assign sck_rise = sck_s2 & ~sck_d;
    assign sck_fall = ~sck_s2 & sck_d;
    assign end_frm  = (state == SHIFT) && ss_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_d    <= 1'b1;
            sck_s1  <= 1'b1;
            sck_s2  <= 1'b1;
            sck_d   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            ss_s1   <= SS_n;
            ss_s2   <= ss_s1;
            ss_d    <= ss_s2;
            sck_s1  <= SCLK;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_n;
    end

    // Synchronizers reset to idle-high, so WAIT_IDLE lets the real pin
    // level flush through before trusting SS_n; otherwise a low SS_n
    // held across reset would look like a fresh frame start.
    always_comb begin
        state_n = state;
        unique case (state)
            WAIT_IDLE: if (flush == 2'd3 && ss_s2) state_n = IDLE;
            IDLE:      if (ss_fall) state_n = SHIFT;
            SHIFT:     if (ss_rise) state_n = IDLE;
            default:   state_n = WAIT_IDLE;
        endcase
    end

    always_comb begin
        MISO = 1'b0;
        if (state == SHIFT) MISO = tx[15];
    end

    // A rise coincident with SS_n rise is folded in before the frame check.
    always_comb begin
        rx_n  = rx;
        cnt_n = bit_cnt;
        if (state == SHIFT && sck_rise) begin
            if (bit_cnt < 5'd16) rx_n = {rx[14:0], mosi_s2};
            if (bit_cnt < 5'd17) cnt_n = bit_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush    <= 2'd0;
            tx       <= 16'h0;
            rx       <= 16'h0;
            bit_cnt  <= 5'd0;
            cur_ch   <= RST_CH;
            frm_done <= 1'b0;
        end else begin
            frm_done <= 1'b0;
            if (state == WAIT_IDLE && flush != 2'd3)
                flush <= flush + 2'd1;
            if (state == IDLE && ss_fall) begin
                tx      <= {4'h0, ch_arr[cur_ch]};
                rx      <= 16'h0;
                bit_cnt <= 5'd0;
            end
            if (state == SHIFT) begin
                rx      <= rx_n;
                bit_cnt <= cnt_n;
                if (sck_fall && bit_cnt != 5'd0)
                    tx <= {tx[14:0], 1'b0};
                if (end_frm && cnt_n >= 5'd16) begin
                    cur_ch   <= rx_n[13:11];
                    frm_done <= 1'b1;
                end
            end
        end
    end

`ifdef A2D_SPI_RESP_PROTO_CHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= end_frm && cnt_n != 5'd0 &&
                     (cnt_n < 5'd16 || cnt_n == 5'd17);
        end
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed frame-table bench for the a2d_spi_resp SPI responder.
module tb_a2d_spi_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [95:0] ch_vals;
    logic [2:0]  cur_ch;
    logic        frm_done;
    logic        proto_err;

    int checks = 0;
    int errors = 0;
    int done_hi = 0;
    int err_hi = 0;

`ifdef A2D_SPI_RESP_PROTO_CHK_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif

    a2d_spi_resp #(.RST_CH(3'd0)) dut (
        .clk(clk),
        .rst(rst),
        .SS_n(SS_n),
        .SCLK(SCLK),
        .MOSI(MOSI),
        .MISO(MISO),
        .ch_vals(ch_vals),
        .cur_ch(cur_ch),
        .frm_done(frm_done),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frm_done) done_hi <= done_hi + 1;
        if (proto_err) err_hi <= err_hi + 1;
    end

    typedef struct {
        logic [15:0] mosi;
        int          nbits;
        int          rst_at;
        int          chg_at;
        int          chg_ch;
        logic [11:0] chg_val;
        logic [15:0] exp_miso;
        logic [2:0]  exp_ch;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        logic [15:0] got = 16'h0;
        logic [15:0] mask;
        int d0 = done_hi;
        int e0 = err_hi;
        int n = (v.nbits > 16) ? 16 : v.nbits;
        mask = 16'hFFFF << (16 - n);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < v.nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? v.mosi[15 - i] : 1'b1;
            if (i == v.chg_at) ch_vals[v.chg_ch*12 +: 12] = v.chg_val;
            if (i == v.rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            repeat (8) @(negedge clk);
            if (i < 16) got[15 - i] = MISO;
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
        end
        SS_n = 1'b1;
        repeat (12) @(negedge clk);
        chk($sformatf("v%0d miso", idx), int'(got & mask),
            int'(v.exp_miso & mask));
        chk($sformatf("v%0d cur_ch", idx), int'(cur_ch), int'(v.exp_ch));
        chk($sformatf("v%0d frm_done", idx), done_hi - d0, v.exp_done);
        chk($sformatf("v%0d proto_err", idx), err_hi - e0, v.exp_err);
    endtask

    initial begin
        ch_vals = '0;
        ch_vals[0*12 +: 12] = 12'hABC;
        ch_vals[1*12 +: 12] = 12'h123;
        ch_vals[2*12 +: 12] = 12'h456;
        ch_vals[3*12 +: 12] = 12'h5A5;
        ch_vals[4*12 +: 12] = 12'h789;
        ch_vals[7*12 +: 12] = 12'h111;

        vecs[0] = '{16'h1800, 16, -1, -1, 0, 12'h0,
                    16'h0ABC, 3'd3, 1, 0};
        vecs[1] = '{16'h3800, 16, -1, -1, 0, 12'h0,
                    16'h05A5, 3'd7, 1, 0};
        vecs[2] = '{16'h1000, 16, -1, 4, 7, 12'hFFF,
                    16'h0111, 3'd2, 1, 0};
        vecs[3] = '{16'hFFFF, 9, -1, -1, 0, 12'h0,
                    16'h0456, 3'd2, 0, ERR_ON};
        vecs[4] = '{16'h3800, 16, 5, -1, 0, 12'h0,
                    16'h0000, 3'd0, 0, 0};
        vecs[5] = '{16'h2000, 16, -1, -1, 0, 12'h0,
                    16'h0ABC, 3'd4, 1, 0};
        vecs[6] = '{16'h0800, 17, -1, -1, 0, 12'h0,
                    16'h0789, 3'd1, 1, ERR_ON};
        vecs[7] = '{16'h0000, 16, -1, -1, 0, 12'h0,
                    16'h0123, 3'd0, 1, 0};

        repeat (3) @(negedge clk);
        chk("rst MISO", int'(MISO), 0);
        chk("rst frm_done", int'(frm_done), 0);
        chk("rst proto_err", int'(proto_err), 0);
        chk("rst cur_ch", int'(cur_ch), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle MISO", int'(MISO), 0);
        chk("idle pulses", done_hi + err_hi, 0);

        for (int k = 0; k < 8; k++) run_frame(k, vecs[k]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/a2d_spi_resp.md
# a2d_spi_resp

Cycle-based SPI responder model of the 8-channel, 12-bit A2D converter that sits on the IR sensor SPI bus. It samples SS_n, SCLK and MOSI with the system clock and decodes the channel address from each 16-bit frame. It returns, on MISO, the 12-bit value of the channel addressed in the previous frame. Used in the IR/line-sensor testbenches and as a synthesizable stand-in for the converter on FPGA bring-up.

## Interface
Parameters:
- RST_CH, 3'd0, channel whose value is returned in the first frame after reset.

Ports:
- clk  in  1  system clock; all logic is clocked on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- SS_n  in  1  SPI slave select, active-low, asynchronous to clk.
- SCLK  in  1  SPI clock, idles high, asynchronous to clk.
- MOSI  in  1  SPI data from the master.
- MISO  out  1  SPI data to the master.
- ch_vals  in  96  channel values; channel n occupies bits [12n+11:12n].
- cur_ch  out  3  channel latched from the last completed frame.
- frm_done  out  1  one-cycle pulse per completed 16-bit frame.
- proto_err  out  1  protocol error pulse; tied 0 unless the macro below is defined.

## Operation
- SS_n, SCLK and MOSI each pass through a 2-flop synchronizer. Edges are detected from the synchronized copies.
- States:
  - WAIT_IDLE: entered on reset. Go to IDLE once synced SS_n = 1.
  - IDLE: on synced SS_n fall, do all of the following, then go to SHIFT:
    - load tx[15:0] = {4'h0, ch_vals[cur_ch]};
    - clear rx[15:0];
    - clear bit_cnt.
  - SHIFT:
    - Synced SCLK rise: rx <= {rx[14:0], MOSI_sync}; bit_cnt++, saturating at 17.
    - Synced SCLK fall with bit_cnt ≥ 1: tx <= {tx[14:0], 1'b0}. A fall with bit_cnt = 0 does not shift, so the MSB survives the leading falling edge.
    - Synced SS_n rise: go to IDLE.
      - If bit_cnt ≥ 16: cur_ch <= rx captured at the 16th rise, bits [13:11]; pulse frm_done.
      - If 1 ≤ bit_cnt ≤ 15 (abort): cur_ch unchanged, no frm_done.
- MISO = tx[15] in SHIFT; MISO = 0 in WAIT_IDLE and IDLE.
- Bits beyond the 16th are ignored; rx is frozen after the 16th rise.
- Channel value is sampled once, at frame start. ch_vals changes mid-frame do not affect the current frame.
- Frame with bit_cnt = 0 at SS_n rise: no effect, no pulses.

## Timing
- Reset values (rst high at clk edge):
  - state = WAIT_IDLE;
  - cur_ch = RST_CH;
  - tx = 0, rx = 0, bit_cnt = 0;
  - MISO = 0, frm_done = 0, proto_err = 0;
  - synchronizers = 1 for SS_n/SCLK, 0 for MOSI.
- Pin-to-detection latency: 3 clk (2 sync flops plus edge register).
- MISO change lags the SCLK falling pin edge by 3 clk, plus 1 clk for the tx register.
- Master constraint: SCLK high and low phases ≥ 6 clk each; SS_n setup to first SCLK edge ≥ 6 clk.
- frm_done asserts the clk after the synced SS_n rise is detected, for exactly 1 clk. cur_ch updates in the same cycle.
- SS_n rise and SCLK rise detected in the same cycle: the SCLK rise is processed first, so a 16th bit completes the frame.
- rst mid-frame: immediate return to reset values. Reset is honoured in every state. With SS_n held low after reset, the remainder of that frame is ignored via WAIT_IDLE.

## Configuration
- Macro A2D_SPI_RESP_PROTO_CHK_EN.
  - Defined: proto_err pulses 1 clk, coincident with the point where frm_done would occur, on either error:
    - an aborted frame (1–15 rises);
    - an over-long frame (≥17 rises).
  - An over-long frame still updates cur_ch and pulses frm_done.
  - Not defined: proto_err is constant 0 and the check logic is absent. Everything else is identical.

## Test plan
- Reset, RST_CH=0, ch_vals ch0=12'hABC: one 16-bit frame with MOSI = 16'h1800 -> MISO bits 16'h0ABC, frm_done 1 pulse, cur_ch = 3.
- Next frame with ch3=12'h5A5 and MOSI = 16'h3800 -> MISO 16'h05A5, cur_ch = 7.
- Change ch_vals[ch7] from 12'h111 to 12'hFFF mid-frame -> MISO still returns 16'h0111.
- Abort after 9 SCLK rises (SS_n high) -> cur_ch unchanged, no frm_done; with the macro defined, proto_err pulses once.
- Assert rst for 1 clk at bit 5 with SS_n held low, then finish that frame -> no frm_done, MISO = 0. A following full frame returns ch_vals[RST_CH].
- 17-rise frame with MOSI = 16'h0800 then an extra 1 -> cur_ch = 1, frm_done pulses; proto_err pulses only with the macro defined.
